tpu_sequencer: RTL and testbench
================================

TPU_SEQUENCER -- requirements
Module: tpu_sequencer

Interface
REQ-001 Parameter IMEM_DEPTH, 8, number of instruction-memory words (power of two, >=2).
REQ-002 Parameter INSTR_W, 16, instruction width; opcode = instr[INSTR_W-1 -: 3], operand = remaining low bits.
REQ-003 Parameter COMPUTE_CYCLES, 6, cycles the sequencer holds after issuing COMPUTE (>=1).
REQ-004 Derived AW = clog2(IMEM_DEPTH).
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-low reset.
REQ-008 prog_we  input  1  program-memory write strobe.
REQ-009 prog_addr  input  AW  program write address.
REQ-010 prog_data  input  INSTR_W  program write data.
REQ-011 start  input  1  begin execution at pc 0.
REQ-012 cmd_ready  input  1  control unit accepts the issued instruction.
REQ-013 instr  output  INSTR_W  instruction being issued.
REQ-014 instr_valid  output  1  instr is valid this cycle.
REQ-015 compute_active  output  1  COMPUTE hold in progress.
REQ-016 pc  output  AW  current program counter.
REQ-017 busy  output  1  high in FETCH, ISSUE and HOLD.
REQ-018 done  output  1  level, high in DONE.
REQ-019 error  output  1  level, high in ERROR.

Function
REQ-020 Opcodes: 000 END, 001 LOAD_ADDR, 010 LOAD_WEIGHT, 011 LOAD_INPUT, 100 COMPUTE, 101 STORE, 110 WAIT (operand = cycle count), 111 illegal.
REQ-021 States: IDLE, FETCH, ISSUE, HOLD, DONE, ERROR; all outputs registered or decoded from registered state only.
REQ-022 prog_we writes imem[prog_addr] only in IDLE, DONE or ERROR; it is ignored while busy=1.
REQ-023 IDLE/DONE/ERROR: start=1 -> pc<=0 and state FETCH; done and error clear on that transition.
REQ-024 Simultaneous prog_we and start: the write completes and the following FETCH observes the new word.
REQ-025 FETCH, 1 cycle: latch imem[pc] into instr; opcode 000 -> DONE; opcode 111 -> ERROR with pc held; otherwise -> ISSUE.
REQ-026 ISSUE: instr_valid=1; state, pc and instr held while cmd_ready=0.
REQ-027 ISSUE with cmd_ready=1 and opcode COMPUTE -> HOLD, counter <= COMPUTE_CYCLES-1, compute_active=1 throughout HOLD.
REQ-028 ISSUE with cmd_ready=1 and opcode WAIT, operand n>0 -> HOLD, counter <= n-1, compute_active=0; n=0 behaves as a single-cycle instruction.
REQ-029 ISSUE with cmd_ready=1 and any other opcode: advance pc (REQ-031).
REQ-030 HOLD: instr_valid=0; counter decrements each cycle; at counter==0, advance pc (REQ-031). HOLD lasts exactly COMPUTE_CYCLES (or n) cycles.
REQ-031 Advance pc: if pc==IMEM_DEPTH-1 -> DONE with pc held (no wrap); else pc<=pc+1 and state FETCH.
REQ-032 Latency: start sampled at edge k -> FETCH in cycle k+1 -> instr_valid=1 in cycle k+2.
REQ-033 start is ignored while busy=1.

Reset
REQ-034 When reset=0 at a rising edge: state IDLE, pc=0, instr=0, counter=0; all outputs 0 the next cycle. This applies in any state, including mid-HOLD.
REQ-035 imem contents are not cleared by reset.

Verification
REQ-036 Load 001_F, 010, 001_1E, 011, 100, 001_7, 101, 000; start at cycle 0 with cmd_ready=1 -> 7 issues, compute_active high in cycles 11-16, done=1 from cycle 22, pc=7.
REQ-037 Hold cmd_ready=0 for 3 cycles on the first ISSUE -> instr_valid stays high and instr is stable for 4 cycles; all later timing shifts by +3.
REQ-038 Program 110 with operand 4, then 000 -> instr_valid for 1 cycle, 4 HOLD cycles with compute_active=0, then DONE.
REQ-039 Word 2 = 111 -> error=1, busy=0, pc=2; a subsequent start restarts from pc 0 and clears error.
REQ-040 Drive reset=0 during the 3rd HOLD cycle of COMPUTE -> next cycle IDLE, all outputs 0; program retained, and a new start reruns the program identically.
REQ-041 Fill all IMEM_DEPTH words with LOAD_ADDR -> after issuing the last word, DONE with pc=IMEM_DEPTH-1 and no wrap; prog_we pulses while busy leave imem unchanged.

Source files
------------

// File: rtl/tpu_sequencer_if.sv
// Sequencer bus: program-load port, start, and the issue handshake
// toward the TPU control unit, plus status back to the host.
interface tpu_sequencer_if #(
   parameter int IMEM_DEPTH = 8,
   parameter int INSTR_W    = 16
);
   localparam int AW = $clog2(IMEM_DEPTH);

   logic               prog_we;
   logic [AW-1:0]      prog_addr;
   logic [INSTR_W-1:0] prog_data;
   logic               start;
   logic               cmd_ready;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               compute_active;
   logic [AW-1:0]      pc;
   logic               busy;
   logic               done;
   logic               error;

   modport master (
      output prog_we, prog_addr, prog_data, start, cmd_ready,
      input  instr, instr_valid, compute_active, pc, busy, done, error
   );

   modport slave (
      input  prog_we, prog_addr, prog_data, start, cmd_ready,
      output instr, instr_valid, compute_active, pc, busy, done, error
   );
endinterface

// File: rtl/tpu_sequencer.sv
// TPU sequencer: steps through a small local program and issues each
// instruction to the control unit, holding for COMPUTE and WAIT.
module tpu_sequencer #(
   parameter int IMEM_DEPTH     = 8,
   parameter int INSTR_W        = 16,
   parameter int COMPUTE_CYCLES = 6
) (
   input  logic           clk,
   input  logic           reset,
   tpu_sequencer_if.slave bus
);
   localparam int AW  = $clog2(IMEM_DEPTH);
   localparam int OW  = INSTR_W - 3;
   localparam int CCW = $clog2(COMPUTE_CYCLES + 1);
   localparam int CW  = (OW > CCW) ? OW : CCW;

   localparam logic [2:0] OP_END  = 3'b000;
   localparam logic [2:0] OP_CMP  = 3'b100;
   localparam logic [2:0] OP_WAIT = 3'b110;
   localparam logic [2:0] OP_ILL  = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_HOLD,
      S_DONE,
      S_ERROR
   } state_t;

   state_t             r_state;
   logic [AW-1:0]      r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic [CW-1:0]      r_cnt;
   logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];

   logic [INSTR_W-1:0] w_fetch;
   logic [2:0]         w_fop;
   logic [2:0]         w_op;
   logic [OW-1:0]      w_opd;
   logic               w_last;
   logic               w_idle;

   assign w_fetch = r_imem[r_pc];
   assign w_fop   = w_fetch[INSTR_W-1 -: 3];
   assign w_op    = r_instr[INSTR_W-1 -: 3];
   assign w_opd   = r_instr[OW-1:0];
   assign w_last  = (r_pc == AW'(IMEM_DEPTH - 1));
   assign w_idle  = (r_state == S_IDLE) || (r_state == S_DONE) ||
                    (r_state == S_ERROR);

   // Program memory survives reset; writes only land while not running.
   always_ff @(posedge clk) begin
      if (bus.prog_we && w_idle)
         r_imem[bus.prog_addr] <= bus.prog_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_instr <= '0;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.start) begin
                  r_pc    <= '0;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               r_instr <= w_fetch;
               if (w_fop == OP_END)
                  r_state <= S_DONE;
               else if (w_fop == OP_ILL)
                  r_state <= S_ERROR;
               else
                  r_state <= S_ISSUE;
            end
            S_ISSUE: begin
               if (bus.cmd_ready) begin
                  if (w_op == OP_CMP) begin
                     r_state <= S_HOLD;
                     r_cnt   <= CW'(COMPUTE_CYCLES - 1);
                  end else if (w_op == OP_WAIT && w_opd != '0) begin
                     r_state <= S_HOLD;
                     r_cnt   <= CW'(w_opd) - CW'(1);
                  end else if (w_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_pc    <= r_pc + AW'(1);
                     r_state <= S_FETCH;
                  end
               end
            end
            S_HOLD: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end else if (w_last) begin
                  r_state <= S_DONE;
               end else begin
                  r_pc    <= r_pc + AW'(1);
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.instr          = r_instr;
   assign bus.instr_valid    = (r_state == S_ISSUE);
   assign bus.compute_active = (r_state == S_HOLD) && (w_op == OP_CMP);
   assign bus.pc             = r_pc;
   assign bus.busy           = (r_state == S_FETCH) ||
                               (r_state == S_ISSUE) ||
                               (r_state == S_HOLD);
   assign bus.done           = (r_state == S_DONE);
   assign bus.error          = (r_state == S_ERROR);
endmodule

// File: tb/tb_tpu_sequencer.sv
// Bench for tpu_sequencer: a program-level reference model queues the
// expected issues; a negedge monitor pops and compares them.
module tb_tpu_sequencer;
   localparam int DEPTH = 8;
   localparam int IW    = 16;
   localparam int CC    = 6;
   localparam int AW    = $clog2(DEPTH);

   typedef struct {
      int          pc;
      logic [15:0] ins;
      int          hold;
      bit          comp;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   tpu_sequencer_if #(.IMEM_DEPTH(DEPTH), .INSTR_W(IW)) bus ();

   tpu_sequencer #(
      .IMEM_DEPTH(DEPTH),
      .INSTR_W(IW),
      .COMPUTE_CYCLES(CC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int          errs = 0;
   int          checks = 0;
   logic [15:0] prog [DEPTH];
   exp_t        exp_q [$];
   bit          mon_en = 1'b0;
   int          rdy_mode = 0;
   int          stall_n = 0;
   int          hold_left = 0;
   bit          hold_comp = 1'b0;
   exp_t        me;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({bus.instr, bus.instr_valid, bus.compute_active, bus.pc,
                  bus.busy, bus.done, bus.error});
   endfunction

   // Walk the program as the host sees it: what gets issued, how long
   // each holds, where it stops and after how many cycles.
   function automatic void model(output bit e_err, output int e_pc,
                                 output int e_t);
      int t;
      int op;
      int opd;
      int h;
      t = 1;
      e_err = 1'b0;
      e_pc = DEPTH - 1;
      e_t = 0;
      for (int p = 0; p < DEPTH; p++) begin
         op = int'(prog[p][15:13]);
         opd = int'(prog[p][12:0]);
         if (op == 0 || op == 7) begin
            e_err = (op == 7);
            e_pc = p;
            e_t = t + 1;
            return;
         end
         h = (op == 4) ? CC : ((op == 6) ? opd : 0);
         exp_q.push_back('{p, prog[p], h, op == 4});
         t += 2 + h;
         if (p == DEPTH - 1) begin
            e_pc = p;
            e_t = t;
            return;
         end
      end
   endfunction

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1)
         bus.cmd_ready = ($urandom_range(0, 3) != 0);
      else if (rdy_mode == 2 && bus.instr_valid && stall_n < 3) begin
         bus.cmd_ready = 1'b0;
         stall_n++;
      end else
         bus.cmd_ready = 1'b1;
   end

   always @(negedge clk) begin
      if (!mon_en)
         hold_left = 0;
      else if (hold_left > 0) begin
         chk("hold", 64'({bus.instr_valid, bus.compute_active, bus.busy}),
             64'({1'b0, hold_comp, 1'b1}));
         hold_left--;
      end else if (bus.instr_valid && bus.cmd_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL issue: got unexpected instr %h pc %0d",
                     bus.instr, bus.pc);
         end else begin
            me = exp_q.pop_front();
            chk("issue", 64'({bus.pc, bus.instr}),
                64'({AW'(me.pc), me.ins}));
            hold_left = me.hold;
            hold_comp = me.comp;
         end
      end
   end

   task automatic load_prog();
      for (int p = 0; p < DEPTH; p++) begin
         @(posedge clk);
         #1;
         bus.prog_we = 1'b1;
         bus.prog_addr = AW'(p);
         bus.prog_data = prog[p];
      end
      @(posedge clk);
      #1;
      bus.prog_we = 1'b0;
   endtask

   task automatic run(input bit wr, input int wa, input logic [15:0] wd,
                      output int ca_f, output int ca_l, output int vc,
                      output int vr);
      bit          e_err;
      int          e_pc;
      int          e_t;
      int          n;
      int          stalls;
      bit          op0_ok;
      bit          fdone;
      logic [15:0] fi;
      if (wr)
         prog[wa] = wd;
      op0_ok = (prog[0][15:13] != 3'b000) && (prog[0][15:13] != 3'b111);
      model(e_err, e_pc, e_t);
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      if (wr) begin
         bus.prog_we = 1'b1;
         bus.prog_addr = AW'(wa);
         bus.prog_data = wd;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.prog_we = 1'b0;
      #1;
      n = 1;
      stalls = 0;
      ca_f = -1;
      ca_l = -1;
      vc = 0;
      vr = 0;
      fdone = 1'b0;
      fi = '0;
      chk("start_fetch", 64'({bus.busy, bus.done, bus.error,
                              bus.instr_valid, bus.pc}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, AW'(0)}));
      while (!(bus.done || bus.error) && n < 3000) begin
         if (n == 2)
            chk("latency", 64'(bus.instr_valid), 64'(op0_ok));
         if (bus.instr_valid && !bus.cmd_ready)
            stalls++;
         if (bus.compute_active) begin
            if (ca_f < 0)
               ca_f = n;
            ca_l = n;
         end
         if (bus.instr_valid) begin
            vc++;
            if (!fdone) begin
               if (vr == 0)
                  fi = bus.instr;
               if (bus.instr == fi)
                  vr++;
            end
         end else if (vr > 0)
            fdone = 1'b1;
         @(posedge clk);
         #2;
         n++;
      end
      chk("no_timeout", 64'(n < 3000), 64'(1));
      chk("end_flags", 64'({bus.done, bus.error, bus.busy}),
          64'({!e_err, e_err, 1'b0}));
      chk("end_pc", 64'(bus.pc), 64'(e_pc));
      chk("end_cycle", 64'(n), 64'(e_t + stalls));
      chk("drained", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
   endtask

   int ca_f;
   int ca_l;
   int vc;
   int vr;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      bus.prog_we = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_outs", outs(), 64'(0));
      reset = 1'b1;
      mon_en = 1'b1;

      prog[0] = 16'h200F;
      prog[1] = 16'h4000;
      prog[2] = 16'h201E;
      prog[3] = 16'h6000;
      prog[4] = 16'h8000;
      prog[5] = 16'h2007;
      prog[6] = 16'hA000;
      prog[7] = 16'h0000;
      load_prog();
      run(0, 0, '0, ca_f, ca_l, vc, vr);
      chk("base_ca_first", 64'(ca_f), 64'(11));
      chk("base_ca_last", 64'(ca_l), 64'(16));
      chk("base_issues", 64'(vc), 64'(7));
      chk("base_vrun", 64'(vr), 64'(1));

      stall_n = 0;
      rdy_mode = 2;
      run(0, 0, '0, ca_f, ca_l, vc, vr);
      rdy_mode = 0;
      chk("stall_ca_first", 64'(ca_f), 64'(14));
      chk("stall_ca_last", 64'(ca_l), 64'(19));
      chk("stall_vrun", 64'(vr), 64'(4));

      // Reset lands in the 3rd COMPUTE hold cycle (cycle 13).
      mon_en = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      chk("hold3_active", 64'({bus.compute_active, bus.busy}), 64'(2'b11));
      reset = 1'b0;
      @(posedge clk);
      #2;
      chk("mid_hold_reset", outs(), 64'(0));
      reset = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      run(0, 0, '0, ca_f, ca_l, vc, vr);
      chk("rerun_ca_first", 64'(ca_f), 64'(11));
      chk("rerun_issues", 64'(vc), 64'(7));

      prog[0] = 16'hC004;
      prog[1] = 16'h0000;
      load_prog();
      run(0, 0, '0, ca_f, ca_l, vc, vr);
      chk("wait_no_ca", 64'(ca_f), 64'(-1));
      chk("wait_issues", 64'(vc), 64'(1));

      prog[0] = 16'hC000;
      prog[1] = 16'h6123;
      prog[2] = 16'hE000;
      load_prog();
      run(0, 0, '0, ca_f, ca_l, vc, vr);
      run(0, 0, '0, ca_f, ca_l, vc, vr);
      run(1, 2, 16'h0000, ca_f, ca_l, vc, vr);

      for (int p = 0; p < DEPTH; p++)
         prog[p] = 16'h2000 | 16'(p);
      load_prog();
      fork
         begin
            repeat (5) @(posedge clk);
            #1;
            bus.prog_we = 1'b1;
            bus.prog_addr = AW'(3);
            bus.prog_data = 16'h0000;
            @(posedge clk);
            #1;
            bus.prog_we = 1'b0;
         end
      join_none
      run(0, 0, '0, ca_f, ca_l, vc, vr);
      chk("fill_issues", 64'(vc), 64'(DEPTH));
      repeat (3) @(posedge clk);
      #2;
      chk("no_wrap", 64'({bus.done, bus.busy, bus.pc}),
          64'({1'b1, 1'b0, AW'(DEPTH - 1)}));
      run(0, 0, '0, ca_f, ca_l, vc, vr);

      rdy_mode = 1;
      for (int k = 0; k < 25; k++) begin
         for (int p = 0; p < DEPTH; p++) begin
            int r;
            int op;
            int opd;
            r = $urandom_range(0, 15);
            op = (r == 0) ? 0 : ((r == 1) ? 7 : $urandom_range(1, 6));
            opd = (op == 6) ? $urandom_range(0, 5) : $urandom_range(0, 8191);
            prog[p] = {3'(op), 13'(opd)};
         end
         load_prog();
         run(0, 0, '0, ca_f, ca_l, vc, vr);
      end
      rdy_mode = 0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
